// File: rtl/pulse_meter.sv
// pulse_meter: synchronizes an asynchronous pulse train and measures the high and
// low width of every complete period, delivering results through a one-entry hold register.
module pulse_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             signal,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic [CNT_W-1:0] pulse_count,
    output logic             overrun
);

    localparam logic [2:0] ST_SETTLE = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_HIGH   = 3'd3;
    localparam logic [2:0] ST_LOW    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Width counters hold at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    logic             s1_r;
    logic             s2_r;
    logic             sp_r;
    logic             rise_s;
    logic             fall_s;
    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic             settle_r;
    logic             settle_nxt_s;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hcnt_nxt_s;
    logic [CNT_W-1:0] lcnt_r;
    logic [CNT_W-1:0] lcnt_nxt_s;
    logic [CNT_W-1:0] hlat_r;
    logic [CNT_W-1:0] hlat_nxt_s;
    logic             emit_s;

    // Two-flop synchronizer followed by the previous-sample flop for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            sp_r <= 1'b0;
        end else begin
            s1_r <= signal;
            s2_r <= s1_r;
            sp_r <= s2_r;
        end
    end

    assign rise_s = s2_r & ~sp_r;
    assign fall_s = ~s2_r & sp_r;

    // Measurement FSM next-state and counter logic
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        hcnt_nxt_s   = hcnt_r;
        lcnt_nxt_s   = lcnt_r;
        hlat_nxt_s   = hlat_r;
        emit_s       = 1'b0;
        case (state_r)
            ST_SETTLE: begin
                if (settle_r) begin
                    state_nxt_s  = ST_ARM;
                    settle_nxt_s = 1'b0;
                end else begin
                    settle_nxt_s = 1'b1;
                end
            end
            // A pulse already high when arming is discarded: wait for a low level first.
            ST_ARM: begin
                if (!s2_r) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_WAIT: begin
                if (rise_s) begin
                    state_nxt_s = ST_HIGH;
                    hcnt_nxt_s  = CNT_ONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    state_nxt_s = ST_LOW;
                    hlat_nxt_s  = hcnt_r;
                    lcnt_nxt_s  = CNT_ONE;
                end else begin
                    hcnt_nxt_s  = sat_inc(hcnt_r);
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    state_nxt_s = ST_HIGH;
                    hcnt_nxt_s  = CNT_ONE;
                    emit_s      = 1'b1;
                end else begin
                    lcnt_nxt_s  = sat_inc(lcnt_r);
                end
            end
            default: begin
                state_nxt_s  = ST_SETTLE;
                settle_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and width counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_SETTLE;
            settle_r <= 1'b0;
            hcnt_r   <= {CNT_W{1'b0}};
            lcnt_r   <= {CNT_W{1'b0}};
            hlat_r   <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            settle_r <= settle_nxt_s;
            hcnt_r   <= hcnt_nxt_s;
            lcnt_r   <= lcnt_nxt_s;
            hlat_r   <= hlat_nxt_s;
        end
    end

    // Holding register, period counter and sticky overrun flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meas_valid  <= 1'b0;
            meas_high   <= {CNT_W{1'b0}};
            meas_low    <= {CNT_W{1'b0}};
            pulse_count <= {CNT_W{1'b0}};
            overrun     <= 1'b0;
        end else begin
            if (emit_s) begin
                pulse_count <= pulse_count + CNT_ONE;
                if (!meas_valid || meas_ready) begin
                    meas_valid <= 1'b1;
                    meas_high  <= hlat_r;
                    meas_low   <= lcnt_r;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end else begin
                meas_valid <= meas_valid;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: an 8-bit and a 4-bit instance share one stimulus;
// accepted measurements are compared against a scoreboard of expected periods.
`timescale 1ns/1ps
module tb_pulse_meter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       signal;
    logic       meas_ready;
    logic       meas_valid8;
    logic [7:0] meas_high8;
    logic [7:0] meas_low8;
    logic [7:0] pulse_count8;
    logic       overrun8;
    logic       meas_valid4;
    logic [3:0] meas_high4;
    logic [3:0] meas_low4;
    logic [3:0] pulse_count4;
    logic       overrun4;

    always #5 clock = ~clock;

    pulse_meter #(.CNT_W(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .signal(signal), .meas_ready(meas_ready),
        .meas_valid(meas_valid8), .meas_high(meas_high8), .meas_low(meas_low8),
        .pulse_count(pulse_count8), .overrun(overrun8)
    );

    pulse_meter #(.CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .signal(signal), .meas_ready(meas_ready),
        .meas_valid(meas_valid4), .meas_high(meas_high4), .meas_low(meas_low4),
        .pulse_count(pulse_count4), .overrun(overrun4)
    );

    typedef struct {
        int h;
        int l;
        int exp_h8;
        int exp_l8;
        int exp_h4;
        int exp_l4;
    } period_t;

    typedef struct {
        int h;
        int l;
        int cnt;
    } meas_t;

    period_t tab[24];
    meas_t   q8[$];
    meas_t   q4[$];
    int      checks = 0;
    int      failures = 0;
    int      exp_count = 0;
    bit      mon_en = 1'b0;
    bit      pend = 1'b0;
    period_t pend_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic period_t mk(input int h, input int l, input int eh8, input int el8,
                                   input int eh4, input int el4);
        period_t p;
        p.h = h; p.l = l; p.exp_h8 = eh8; p.exp_l8 = el8; p.exp_h4 = eh4; p.exp_l4 = el4;
        return p;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_meas(input period_t p);
        exp_count++;
        q8.push_back('{p.exp_h8, p.exp_l8, exp_count % 256});
        q4.push_back('{p.exp_h4, p.exp_l4, exp_count % 16});
    endtask

    // A period is only complete once the following rise arrives, so its expectation is queued then.
    task automatic drive_period(input period_t p);
        signal = 1'b1;
        if (pend) push_meas(pend_p);
        cyc(p.h);
        signal = 1'b0;
        cyc(p.l);
        pend   = 1'b1;
        pend_p = p;
    endtask

    task automatic final_rise();
        signal = 1'b1;
        if (pend) push_meas(pend_p);
        pend = 1'b0;
        cyc(6);
    endtask

    task automatic clear_model();
        q8.delete();
        q4.delete();
        exp_count = 0;
        pend = 1'b0;
    endtask

    task automatic do_reset(input logic sig);
        reset_n = 1'b0;
        signal  = sig;
        clear_model();
        cyc(2);
        check("reset valid8", 32'(meas_valid8), 32'd0);
        check("reset high8", 32'(meas_high8), 32'd0);
        check("reset low8", 32'(meas_low8), 32'd0);
        check("reset count8", 32'(pulse_count8), 32'd0);
        check("reset overrun8", 32'(overrun8), 32'd0);
        check("reset valid4", 32'(meas_valid4), 32'd0);
        reset_n = 1'b1;
    endtask

    // Scoreboard: every accepted measurement must match the oldest expectation.
    always @(negedge clock) begin : mon8
        meas_t m;
        if (mon_en && reset_n && meas_valid8 && meas_ready) begin
            check("d8 expected measurement", 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) begin
                m = q8.pop_front();
                check("d8 high", 32'(meas_high8), m.h);
                check("d8 low", 32'(meas_low8), m.l);
                check("d8 count", 32'(pulse_count8), m.cnt);
                check("d8 overrun", 32'(overrun8), 32'd0);
            end
        end
    end

    always @(negedge clock) begin : mon4
        meas_t m;
        if (mon_en && reset_n && meas_valid4 && meas_ready) begin
            check("d4 expected measurement", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) begin
                m = q4.pop_front();
                check("d4 high", 32'(meas_high4), m.h);
                check("d4 low", 32'(meas_low4), m.l);
                check("d4 count", 32'(pulse_count4), m.cnt);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        signal     = 1'b0;
        meas_ready = 1'b0;

        tab[0] = mk(5, 5, 5, 5, 5, 5);
        tab[1] = mk(5, 5, 5, 5, 5, 5);
        tab[2] = mk(5, 5, 5, 5, 5, 5);
        tab[3] = mk(5, 5, 5, 5, 5, 5);
        tab[4] = mk(3, 4, 3, 4, 3, 4);
        tab[5] = mk(1, 1, 1, 1, 1, 1);
        tab[6] = mk(2, 9, 2, 9, 2, 9);
        tab[7] = mk(20, 2, 20, 2, 15, 2);
        for (int i = 8; i < 24; i++) tab[i] = mk(1, 2, 1, 2, 1, 2);

        // Long train: steady 5/5, mixed widths, 4-bit saturation and count wrap
        do_reset(1'b0);
        meas_ready = 1'b1;
        mon_en     = 1'b1;
        cyc(5);
        for (int i = 0; i < 24; i++) drive_period(tab[i]);
        final_rise();
        check("train q8 drained", q8.size(), 32'd0);
        check("train q4 drained", q4.size(), 32'd0);
        check("train count8 total", 32'(pulse_count8), 32'd24);
        check("train count4 wrapped", 32'(pulse_count4), 32'd8);

        // Pulse in progress at reset release is discarded
        do_reset(1'b1);
        cyc(7);
        signal = 1'b0;
        cyc(4);
        drive_period(mk(3, 4, 3, 4, 3, 4));
        drive_period(mk(3, 4, 3, 4, 3, 4));
        final_rise();
        check("partial q8 drained", q8.size(), 32'd0);
        check("partial count8", 32'(pulse_count8), 32'd2);

        // Overrun: consumer stalled across two periods
        mon_en     = 1'b0;
        meas_ready = 1'b0;
        do_reset(1'b0);
        cyc(5);
        drive_period(mk(4, 6, 4, 6, 4, 6));
        drive_period(mk(2, 8, 2, 8, 2, 8));
        final_rise();
        check("ovr valid8", 32'(meas_valid8), 32'd1);
        check("ovr high8", 32'(meas_high8), 32'd4);
        check("ovr low8", 32'(meas_low8), 32'd6);
        check("ovr overrun8", 32'(overrun8), 32'd1);
        check("ovr count8", 32'(pulse_count8), 32'd2);
        meas_ready = 1'b1;
        cyc(1);
        meas_ready = 1'b0;
        check("ovr valid8 after accept", 32'(meas_valid8), 32'd0);
        check("ovr overrun8 sticky", 32'(overrun8), 32'd1);

        // Accept and emit on the same edge
        do_reset(1'b0);
        cyc(5);
        drive_period(mk(3, 3, 3, 3, 3, 3));
        drive_period(mk(2, 5, 2, 5, 2, 5));
        signal = 1'b1;
        cyc(2);
        check("same held valid8", 32'(meas_valid8), 32'd1);
        check("same held high8", 32'(meas_high8), 32'd3);
        meas_ready = 1'b1;
        cyc(1);
        meas_ready = 1'b0;
        check("same valid8", 32'(meas_valid8), 32'd1);
        check("same high8", 32'(meas_high8), 32'd2);
        check("same low8", 32'(meas_low8), 32'd5);
        check("same overrun8", 32'(overrun8), 32'd0);
        check("same count8", 32'(pulse_count8), 32'd2);

        // Asynchronous reset mid-HIGH while a measurement is held
        do_reset(1'b0);
        cyc(5);
        drive_period(mk(4, 4, 4, 4, 4, 4));
        signal = 1'b1;
        cyc(4);
        check("mid pre valid8", 32'(meas_valid8), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid async valid8", 32'(meas_valid8), 32'd0);
        check("mid async high8", 32'(meas_high8), 32'd0);
        check("mid async low8", 32'(meas_low8), 32'd0);
        check("mid async count8", 32'(pulse_count8), 32'd0);
        cyc(2);
        clear_model();
        reset_n    = 1'b1;
        meas_ready = 1'b1;
        mon_en     = 1'b1;
        cyc(6);
        signal = 1'b0;
        cyc(4);
        check("mid no early valid8", 32'(meas_valid8), 32'd0);
        drive_period(mk(5, 3, 5, 3, 5, 3));
        drive_period(mk(2, 2, 2, 2, 2, 2));
        final_rise();
        check("mid q8 drained", q8.size(), 32'd0);
        check("mid count8", 32'(pulse_count8), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
